wave_sequencer: RTL and testbench



---
 rtl/wave_sequencer.sv | 122 ++++++++++++
 tb/tb_wave_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// Tone-segment sequencer: steps the waveform generator through a programmed
// table of (phase step, duration) segments, with optional gaps and looping.
module wave_sequencer #(
    parameter int NSEG   = 8,
    parameter int STEP_W = 16,
    parameter int DUR_W  = 16,
    parameter int GAP    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [$clog2(NSEG)-1:0] cfg_addr,
    input  logic [STEP_W-1:0]       cfg_step,
    input  logic [DUR_W-1:0]        cfg_dur,
    input  logic [$clog2(NSEG):0]   num_segs,
    input  logic                    loop_en,
    input  logic                    start,
    input  logic                    stop,
    output logic                    gen_en,
    output logic [STEP_W-1:0]       gen_step,
    output logic                    phase_clr,
    output logic [$clog2(NSEG)-1:0] seg_idx,
    output logic                    busy,
    output logic                    done
);
    localparam int AW = $clog2(NSEG);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_FIN} state_t;

    state_t            state;
    logic [STEP_W-1:0] tbl_step [NSEG];
    logic [DUR_W-1:0]  tbl_dur  [NSEG];
    logic [DUR_W-1:0]  cnt;
    logic [GW-1:0]     gap_cnt;
    logic [AW:0]       nsegs_l;

    logic          last_seg, num_ok, addr_ok, enter, finish;
    logic [AW-1:0] ent_idx;

    assign last_seg = ({1'b0, seg_idx} == nsegs_l - (AW+1)'(1));
    assign num_ok   = (num_segs != '0) && (num_segs <= (AW+1)'(NSEG));
    assign addr_ok  = ({1'b0, cfg_addr} < (AW+1)'(NSEG));
    // A fresh start always begins at entry 0; otherwise wrap or step forward.
    assign ent_idx  = (state == S_IDLE || last_seg) ? '0 : seg_idx + AW'(1);
    assign finish   = (state == S_PLAY) && (cnt == DUR_W'(1)) && last_seg && !loop_en;

    always_comb begin
        enter = 1'b0;
        if (!stop) begin
            case (state)
                S_IDLE:  enter = start && num_ok;
                S_PLAY:  enter = (cnt == DUR_W'(1)) && !finish && (GAP == 0);
                S_GAP:   enter = (gap_cnt == GW'(1));
                default: enter = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            gen_en    <= 1'b0;
            gen_step  <= '0;
            phase_clr <= 1'b0;
            seg_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            gap_cnt   <= '0;
            nsegs_l   <= '0;
            for (int i = 0; i < NSEG; i++) begin
                tbl_step[i] <= '0;
                tbl_dur[i]  <= '0;
            end
        end else begin
            if (cfg_we && addr_ok) begin
                tbl_step[cfg_addr] <= cfg_step;
                tbl_dur[cfg_addr]  <= cfg_dur;
            end
            phase_clr <= 1'b0;
            done      <= 1'b0;
            if (stop) begin
                state   <= S_IDLE;
                gen_en  <= 1'b0;
                busy    <= 1'b0;
                seg_idx <= '0;
            end else if (enter) begin
                // Step and duration are captured here, so later table writes
                // only affect the next entry of that segment.
                if (state == S_IDLE) nsegs_l <= num_segs;
                state     <= S_PLAY;
                seg_idx   <= ent_idx;
                gen_step  <= tbl_step[ent_idx];
                gen_en    <= 1'b1;
                phase_clr <= 1'b1;
                busy      <= 1'b1;
                cnt       <= (tbl_dur[ent_idx] == '0) ? DUR_W'(1) : tbl_dur[ent_idx];
            end else begin
                case (state)
                    S_PLAY: begin
                        if (finish) begin
                            state  <= S_FIN;
                            gen_en <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else if (cnt == DUR_W'(1)) begin
                            state   <= S_GAP;
                            gen_en  <= 1'b0;
                            gap_cnt <= GW'(GAP);
                        end else begin
                            cnt <= cnt - DUR_W'(1);
                        end
                    end
                    S_GAP:   gap_cnt <= gap_cnt - GW'(1);
                    S_FIN:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wave_sequencer.sv
// Bench for wave_sequencer: two instances (GAP=0 and GAP=2) driven in lockstep,
// expected timelines planned from the segment rules, pulses matched via queues.
module tb_wave_sequencer;
    localparam int NC = 30000;

    logic        clk = 1'b0;
    logic        reset, cfg_we, loop_en, start, stop;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_step, cfg_dur;
    logic [3:0]  num_segs;
    logic        gen_en [2];
    logic [15:0] gen_step [2];
    logic        phase_clr [2];
    logic [2:0]  seg_idx [2];
    logic        busy [2];
    logic        done [2];

    wave_sequencer #(.NSEG(8), .STEP_W(16), .DUR_W(16), .GAP(0)) u_g0 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_step(cfg_step), .cfg_dur(cfg_dur), .num_segs(num_segs),
        .loop_en(loop_en), .start(start), .stop(stop), .gen_en(gen_en[0]),
        .gen_step(gen_step[0]), .phase_clr(phase_clr[0]), .seg_idx(seg_idx[0]),
        .busy(busy[0]), .done(done[0]));

    wave_sequencer #(.NSEG(8), .STEP_W(16), .DUR_W(16), .GAP(2)) u_g2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_step(cfg_step), .cfg_dur(cfg_dur), .num_segs(num_segs),
        .loop_en(loop_en), .start(start), .stop(stop), .gen_en(gen_en[1]),
        .gen_step(gen_step[1]), .phase_clr(phase_clr[1]), .seg_idx(seg_idx[1]),
        .busy(busy[1]), .done(done[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        logic [2:0]  idx;
        logic [15:0] step;
    } ev_t;

    bit          exp_busy [2][NC];
    bit          exp_en   [2][NC];
    logic [15:0] exp_step [2][NC];
    logic [2:0]  exp_idx  [2][NC];
    ev_t         q_pc [2][$];
    int          q_dn [2][$];
    logic [15:0] m_step [8];
    logic [15:0] m_dur  [8];
    bit          pw_en;
    int          pw_cyc;
    logic [15:0] pw_step, pw_dur;
    int          errors = 0, checks = 0;
    bit          mon_on = 1'b0;

    task automatic chk(input string nm, input int d, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, act, exp);
        end
    endtask

    // Timeline for one run: start driven in cycle c, stop/reset driven in
    // cycle s (nothing from s+1 on). Entry at cycle t sees writes made by t-2.
    function automatic int plan(int d, int c, int s, int n, bit lp);
        int t = c + 1, idx = 0, g = 2 * d, last = c, dd, te;
        logic [15:0] st, du;
        ev_t e;
        while (t <= s) begin
            st = m_step[idx];
            du = m_dur[idx];
            if (pw_en && idx == 0 && pw_cyc <= t - 2) begin
                st = pw_step;
                du = pw_dur;
            end
            dd = (du == 0) ? 1 : int'(du);
            e.t = t; e.idx = 3'(idx); e.step = st;
            q_pc[d].push_back(e);
            for (int k = t; k < t + dd && k <= s && k < NC; k++) begin
                exp_en[d][k] = 1'b1; exp_busy[d][k] = 1'b1;
                exp_step[d][k] = st; exp_idx[d][k] = 3'(idx);
            end
            te = t + dd;
            last = te;
            if (idx == n - 1 && !lp) begin
                if (te <= s) q_dn[d].push_back(te);
                break;
            end
            for (int k = te; k < te + g && k <= s && k < NC; k++) begin
                exp_busy[d][k] = 1'b1; exp_step[d][k] = st; exp_idx[d][k] = 3'(idx);
            end
            t = te + g;
            idx = (idx == n - 1) ? 0 : idx + 1;
        end
        return last;
    endfunction

    always @(negedge clk) begin : mon
        ev_t e;
        int  t;
        if (mon_on && cyc < NC) begin
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, busy[d], exp_busy[d][cyc]);
                chk("gen_en", d, gen_en[d], exp_en[d][cyc]);
                if (exp_busy[d][cyc]) begin
                    chk("gen_step", d, gen_step[d], exp_step[d][cyc]);
                    chk("seg_idx", d, seg_idx[d], exp_idx[d][cyc]);
                end
                if (phase_clr[d]) begin
                    if (q_pc[d].size() == 0) chk("phase_clr_unexpected", d, 1, 0);
                    else begin
                        e = q_pc[d].pop_front();
                        chk("phase_clr_time", d, cyc, e.t);
                        chk("entry_idx", d, seg_idx[d], e.idx);
                        chk("entry_step", d, gen_step[d], e.step);
                    end
                end else if (q_pc[d].size() > 0 && q_pc[d][0].t < cyc) begin
                    e = q_pc[d].pop_front();
                    chk("phase_clr_missing", d, 0, e.t);
                end
                if (done[d]) begin
                    if (q_dn[d].size() == 0) chk("done_unexpected", d, 1, 0);
                    else begin
                        t = q_dn[d].pop_front();
                        chk("done_time", d, cyc, t);
                    end
                end else if (q_dn[d].size() > 0 && q_dn[d][0] < cyc) begin
                    t = q_dn[d].pop_front();
                    chk("done_missing", d, 0, t);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int st, input int du);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_step = 16'(st); cfg_dur = 16'(du);
        tick();
        cfg_we = 1'b0;
        m_step[a] = 16'(st);
        m_dur[a]  = 16'(du);
    endtask

    // stop_at/pw_off are offsets from the start cycle; negative means none.
    task automatic run(input int n, input bit lp, input int stop_at, input bit with_stop,
                       input bit rst, input int pw_off, input int pw_s, input int pw_d);
        int c, s, e0, e1, endc;
        c = cyc;
        s = (stop_at < 0) ? NC - 1 : c + stop_at;
        pw_en = (pw_off >= 0); pw_cyc = c + pw_off; pw_step = 16'(pw_s); pw_dur = 16'(pw_d);
        e0 = c; e1 = c;
        if (n >= 1 && n <= 8 && !with_stop) begin
            e0 = plan(0, c, s, n, lp);
            e1 = plan(1, c, s, n, lp);
        end
        endc = (e0 > e1) ? e0 : e1;
        if (stop_at >= 0 && s + 1 > endc) endc = s + 1;
        endc = endc + 2;
        num_segs = 4'(n); loop_en = lp; start = 1'b1; stop = with_stop;
        tick();
        start = 1'b0; stop = 1'b0;
        while (cyc < endc) begin
            stop   = (stop_at >= 0 && cyc == s && !rst);
            reset  = (stop_at >= 0 && cyc == s && rst);
            cfg_we = pw_en && cyc == pw_cyc;
            cfg_addr = 3'd0; cfg_step = pw_step; cfg_dur = pw_dur;
            tick();
        end
        stop = 1'b0; reset = 1'b0; cfg_we = 1'b0;
        if (pw_en) begin m_step[0] = pw_step; m_dur[0] = pw_dur; end
        pw_en = 1'b0;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m_step[i] = '0; m_dur[i] = '0; end
            for (int d = 0; d < 2; d++) begin
                chk("post_reset_step", d, gen_step[d], 0);
                chk("post_reset_idx", d, seg_idx[d], 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_step = '0; cfg_dur = '0;
        num_segs = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; pw_en = 1'b0;
        for (int i = 0; i < 8; i++) begin m_step[i] = '0; m_dur[i] = '0; end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        mon_on = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_step", d, gen_step[d], 0);
            chk("reset_idx", d, seg_idx[d], 0);
            chk("reset_phase_clr", d, phase_clr[d], 0);
            chk("reset_done", d, done[d], 0);
        end

        wr(0, 100, 3); wr(1, 200, 2);
        run(2, 0, -1, 0, 0, -1, 0, 0);          // plain two-segment play
        run(2, 1, 7, 0, 0, -1, 0, 0);           // loop then stop
        wr(0, 100, 1); wr(1, 200, 1);
        run(2, 0, -1, 0, 0, -1, 0, 0);          // short segments, gap visible on u_g2
        run(0, 0, -1, 0, 0, -1, 0, 0);          // illegal counts are ignored
        run(9, 0, -1, 0, 0, -1, 0, 0);
        run(2, 0, -1, 1, 0, -1, 0, 0);          // start together with stop
        wr(0, 100, 4);
        run(1, 1, 12, 0, 0, 2, 555, 4);         // rewrite playing entry
        wr(0, 7, 0);
        run(1, 0, -1, 0, 0, -1, 0, 0);          // zero duration plays one cycle
        wr(0, 100, 5); wr(1, 200, 5);
        run(2, 0, 3, 0, 1, -1, 0, 0);           // reset mid-play
        run(1, 0, -1, 0, 0, -1, 0, 0);          // cleared table: step 0, dur 0

        for (int r = 0; r < 40; r++) begin
            int n, sa;
            bit lp, ws;
            for (int a = 0; a < 8; a++) wr(a, int'($urandom_range(0, 65535)), int'($urandom_range(0, 5)));
            n  = int'($urandom_range(0, 9));
            lp = 1'($urandom_range(0, 1));
            ws = ($urandom_range(0, 9) == 0);
            sa = (lp || $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            run(n, lp, sa, ws, 0, -1, 0, 0);
        end

        for (int d = 0; d < 2; d++) begin
            chk("pending_phase_clr", d, q_pc[d].size(), 0);
            chk("pending_done", d, q_dn[d].size(), 0);
        end
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
